sseg_scan_driver: RTL and testbench



---
 rtl/sseg_pkg.sv | 37 +++
 rtl/sseg_scan_driver_hex.sv | 13 +
 rtl/sseg_scan_driver.sv | 155 +++++++++++++++
 tb/tb_sseg_scan_driver.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and helpers for the seven-segment driver.
// Patterns are {g,f,e,d,c,b,a}, active-high unless passed through pol7.
package sseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] pol7(
    input logic [6:0] s,
    input bit         al
  );
    return al ? ~s : s;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_hex.sv
// hex_to_sseg: combinational nibble decoder with blanking.
// Output is active-high; polarity is applied by the caller.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : hex7(nib_i);

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multiplexed hex display with a shadow register
// committed only at frame boundaries so digits never tear.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV        = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dot,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_ack
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam bit AL = (ACTIVE_LOW != 0);

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pval_q, pval_d;
  logic [VW-1:0]     aval_q, aval_d;
  logic [DIGITS-1:0] pdp_q, pdp_d;
  logic [DIGITS-1:0] adp_q, adp_d;
  logic              pblz_q, pblz_d;
  logic              ablz_q, ablz_d;
  logic              pend_q, pend_d;
  logic              tick, boundary, commit;

  logic [DIGITS-1:0] lz;
  logic              lz_run;
  logic [DIGITS-1:0] sel;
  logic [3:0]        nib;
  logic [6:0]        pat;

  logic [6:0]        seg_q;
  logic              dot_q;
  logic [DIGITS-1:0] an_q;
  logic              ack1_q;
  logic              ack_q;

  assign tick     = (pcnt_q == PW'(DIV - 1));
  assign boundary = tick && (idx_q == IW'(DIGITS - 1));

  // Prescaler, digit index, and shadow/commit next state.
  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    pval_d = pval_q;
    pdp_d  = pdp_q;
    pblz_d = pblz_q;
    aval_d = aval_q;
    adp_d  = adp_q;
    ablz_d = ablz_q;
    pend_d = pend_q;
    commit = 1'b0;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end
    if (boundary && pend_q) begin
      aval_d = pval_q;
      adp_d  = pdp_q;
      ablz_d = pblz_q;
      pend_d = 1'b0;
      commit = 1'b1;
    end else if (boundary && load) begin
      aval_d = value;
      adp_d  = dp;
      ablz_d = blank_lz;
      commit = 1'b1;
    end
    if (load) begin
      pval_d = value;
      pdp_d  = dp;
      pblz_d = blank_lz;
      pend_d = !(boundary && !pend_q);
    end
  end

  // Counter and shadow/active register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      pval_q <= '0;
      pdp_q  <= '0;
      pblz_q <= 1'b0;
      aval_q <= '0;
      adp_q  <= '0;
      ablz_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      pblz_q <= pblz_d;
      aval_q <= aval_d;
      adp_q  <= adp_d;
      ablz_q <= ablz_d;
      pend_q <= pend_d;
    end
  end

  // Leading-zero mask: digit i blanks when it and all above are zero.
  always_comb begin
    lz_run = ablz_q;
    lz     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (aval_q[4*i +: 4] == 4'h0);
      lz[i]  = lz_run;
    end
    lz[0] = 1'b0;
  end

  assign sel = DIGITS'(1) << idx_q;
  assign nib = aval_q[{idx_q, 2'b00} +: 4];

  hex_to_sseg u_dec (
    .nib_i   (nib),
    .blank_i (lz[idx_q]),
    .seg_o   (pat)
  );

  // Registered display outputs; ack delayed to align with new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q  <= pol7(SEG_OFF, AL);
      dot_q  <= AL;
      an_q   <= {DIGITS{AL}};
      ack1_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      seg_q  <= pol7(pat, AL);
      dot_q  <= AL ^ adp_q[idx_q];
      an_q   <= {DIGITS{AL}} ^ sel;
      ack1_q <= commit;
      ack_q  <= ack1_q;
    end
  end

  assign seg       = seg_q;
  assign dot       = dot_q;
  assign an        = an_q;
  assign frame_ack = ack_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: scoreboard bench for the scan driver.
// Expected frames are queued at load time and popped on frame_ack.
module tb_sseg_scan_driver;

  localparam int DG = 4;
  localparam int DV = 4;
  localparam int FR = DG * DV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dot;
  logic [3:0]  an;
  logic        frame_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bpend = 1'b0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .DIGITS     (DG),
    .DIV        (DV),
    .ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .dp        (dp),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dot       (dot),
    .an        (an),
    .frame_ack (frame_ack)
  );

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06;
      4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D;
      4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F;
      4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E;
      4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // {seg digit3..digit0 (7 bits each), dots}
  function automatic logic [31:0] expect_frame(
    input logic [15:0] v, input logic [3:0] d, input logic b);
    logic [27:0] s;
    logic lead;
    s = '0;
    lead = b;
    for (int i = 3; i >= 0; i--) begin
      lead = lead && (v[4*i +: 4] == 4'h0);
      s[7*i +: 7] = (lead && i != 0) ? 7'h00 : font(v[4*i +: 4]);
    end
    return {s, d};
  endfunction

  task automatic step;
    if (cyc % FR == FR - 1 && bpend) bpend = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_load(
    input logic [15:0] v, input logic [3:0] d, input logic b);
    bit bnd;
    bnd = (cyc % FR == FR - 1);
    value = v;
    dp = d;
    blank_lz = b;
    load = 1'b1;
    if (bpend && !bnd) sb[sb.size()-1] = expect_frame(v, d, b);
    else sb.push_back(expect_frame(v, d, b));
    if (!bnd) bpend = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    load = 1'b0;
  endtask

  task automatic wait_to(input int off);
    while (cyc % FR != off) step();
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (frame_ack !== 1'b1 && lat < 3 * FR) begin
      step();
      lat++;
    end
    if (frame_ack !== 1'b1) lat = -1;
  endtask

  task automatic grab(output logic [27:0] s, output logic [3:0] d,
                      output int bad, output int nack);
    logic [3:0] one;
    int di;
    one = 4'b0001;
    s = '0;
    d = '0;
    bad = 0;
    nack = 0;
    for (int j = 0; j < FR; j++) begin
      di = j / DV;
      if (j % DV == 0) begin
        s[7*di +: 7] = seg;
        d[di] = dot;
      end else if (seg !== s[7*di +: 7] || dot !== d[di]) bad++;
      if (an !== (one << di)) bad++;
      if (frame_ack === 1'b1) nack++;
      step();
    end
  endtask

  task automatic reset_release;
    rst_n = 1'b1;
    cyc = 0;
    bpend = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    logic [3:0] one;
    logic [31:0] e;
    logic [27:0] s;
    logic [3:0] d;
    int bad, nack, lat, due;
    one = 4'b0001;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({seg, dot, an, frame_ack} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0", {seg, dot, an, frame_ack});
    end
    reset_release();
    checks++;
    if (an !== 4'h0) begin
      errors++;
      $display("FAIL first_cycle_off: an=%b want 0000", an);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % DV == 1) begin
        checks++;
        if (an !== (one << ((k / DV) % DG)) || seg !== 7'h3F) begin
          errors++;
          $display("FAIL walk k=%0d: an=%b seg=%h want an=%b seg=3f",
                   k, an, seg, one << ((k / DV) % DG));
        end
      end
    end
    due = FR - (cyc % FR);
    do_load(16'h0000, 4'h0, 1'b1);
    wait_ack(lat);
    checks++;
    if (lat != due) begin
      errors++;
      $display("FAIL zero_latency: got %0d want %0d", lat, due);
    end
    e = sb.pop_front();
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || bad != 0 || nack != 1) begin
      errors++;
      $display("FAIL zero_frame: got %h bad=%0d ack=%0d want %h",
               {s, d}, bad, nack, e);
    end
  endtask

  task automatic test_mid_frame;
    logic [31:0] e;
    logic [27:0] s;
    logic [3:0] d;
    int bad, nack, lat, due;
    wait_to(6);
    due = FR - (cyc % FR);
    do_load(16'h12AF, 4'h0, 1'b0);
    wait_ack(lat);
    checks++;
    if (lat != due) begin
      errors++;
      $display("FAIL mid_latency: got %0d want %0d", lat, due);
    end
    e = sb.pop_front();
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || bad != 0 || nack != 1) begin
      errors++;
      $display("FAIL mid_frame: got %h bad=%0d ack=%0d want %h",
               {s, d}, bad, nack, e);
    end
  endtask

  task automatic test_blank;
    logic [31:0] e;
    logic [27:0] s;
    logic [3:0] d;
    int bad, nack, lat;
    wait_to(3);
    do_load(16'h0005, 4'b0100, 1'b1);
    wait_ack(lat);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL blank_ack: got timeout want ack");
    end
    e = sb.pop_front();
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || bad != 0) begin
      errors++;
      $display("FAIL blank_frame: got %h bad=%0d want %h", {s, d}, bad, e);
    end
    checks++;
    if (d !== 4'b0100 || s[20:7] !== 14'h0 || s[6:0] !== 7'h6D) begin
      errors++;
      $display("FAIL blank_digits: got %h/%b want 000006d/0100", s, d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    logic [27:0] s;
    logic [3:0] d;
    int bad, nack, lat;
    wait_to(2);
    do_load(16'h1111, 4'h0, 1'b0);
    wait_to(8);
    do_load(16'h2222, 4'h0, 1'b0);
    checks++;
    if (sb.size() != 1) begin
      errors++;
      $display("FAIL b2b_queue: got %0d want 1", sb.size());
    end
    wait_ack(lat);
    e = sb.pop_front();
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || bad != 0 || nack != 1 || lat < 0) begin
      errors++;
      $display("FAIL b2b_frame: got %h bad=%0d ack=%0d want %h",
               {s, d}, bad, nack, e);
    end
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || bad != 0 || nack != 0) begin
      errors++;
      $display("FAIL b2b_stale: got %h ack=%0d want %h ack=0",
               {s, d}, nack, e);
    end
  endtask

  task automatic test_boundary_load;
    logic [31:0] e;
    logic [27:0] s;
    logic [3:0] d;
    int bad, nack, lat;
    wait_to(4);
    do_load(16'h4444, 4'h0, 1'b0);
    wait_to(FR - 1);
    do_load(16'h3333, 4'h0, 1'b0);
    wait_ack(lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL bnd_lat1: got %0d want 1", lat);
    end
    e = sb.pop_front();
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || s !== {4{7'h66}} || bad != 0 || nack != 1) begin
      errors++;
      $display("FAIL bnd_first: got %h want %h", {s, d}, e);
    end
    wait_ack(lat);
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL bnd_lat2: got %0d want 0", lat);
    end
    e = sb.pop_front();
    grab(s, d, bad, nack);
    checks++;
    if ({s, d} !== e || s !== {4{7'h4F}} || bad != 0 || nack != 1) begin
      errors++;
      $display("FAIL bnd_second: got %h want %h", {s, d}, e);
    end
  endtask

  task automatic test_reset_pending;
    logic [27:0] s;
    logic [3:0] d;
    int bad, nack, n2;
    wait_to(3);
    do_load(16'h7777, 4'h0, 1'b0);
    step();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({seg, dot, an, frame_ack} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_off: got %h want 0", {seg, dot, an, frame_ack});
    end
    reset_release();
    step();
    checks++;
    if (an !== 4'b0001 || seg !== 7'h3F) begin
      errors++;
      $display("FAIL rst_mid_d0: an=%b seg=%h want 0001/3f", an, seg);
    end
    grab(s, d, bad, nack);
    grab(s, d, bad, n2);
    checks++;
    if (s !== {4{7'h3F}} || d !== 4'h0 || bad != 0 || nack + n2 != 0) begin
      errors++;
      $display("FAIL rst_mid_lost: got %h/%b ack=%0d want 3f x4, no ack",
               s, d, nack + n2);
    end
  endtask

  initial begin
    test_reset();
    test_mid_frame();
    test_blank();
    test_back_to_back();
    test_boundary_load();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
